// File: rtl/branch_stats_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_stats_unit_if
//  Description : Memory-mapped register port of the branch statistics unit.
//                The master (CPU decode) drives the address and the strobes.
//                The slave (the statistics unit) returns registered read data.
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_stats_unit_if;
  logic [3:0]  addr;
  logic        re;
  logic        we;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rd_vld;

  modport master (output addr, output re, output we, output wdata,
                  input  rdata, input rd_vld);
  modport slave  (input  addr, input re, input we, input wdata,
                  output rdata, output rd_vld);
endinterface
`default_nettype wire

// File: rtl/branch_stats_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_stats_unit
//  Description : Three wide counters (branches, BTB hits, mispredictions).
//                They are read through a 16-bit register port. The port gives
//                atomic LO/HI snapshot reads, freeze/clear control and sticky
//                overflow flags.
//  Config      : BRSTAT_SAT_EN - when defined, counters saturate at all-ones
//                instead of wrapping to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_stats_unit #(
  parameter int CNT_W = 32
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  input  wire logic           inc_br_cnt,
  input  wire logic           inc_hit_cnt,
  input  wire logic           inc_mispr_cnt,
  branch_stats_unit_if.slave  bus,
  output logic                ovf_irq
);

  localparam int HI_W = CNT_W - 16;

`ifdef BRSTAT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [3:0] A_BR_LO  = 4'd0;
  localparam logic [3:0] A_BR_HI  = 4'd1;
  localparam logic [3:0] A_HIT_LO = 4'd2;
  localparam logic [3:0] A_HIT_HI = 4'd3;
  localparam logic [3:0] A_MIS_LO = 4'd4;
  localparam logic [3:0] A_MIS_HI = 4'd5;
  localparam logic [3:0] A_CTRL   = 4'd6;
  localparam logic [3:0] A_STATUS = 4'd7;

  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
  logic [HI_W-1:0]  br_snap_q, br_snap_d;
  logic [HI_W-1:0]  hit_snap_q, hit_snap_d;
  logic [HI_W-1:0]  mis_snap_q, mis_snap_d;
  logic             freeze_q, freeze_d;
  logic [2:0]       status_q, status_d;
  logic [15:0]      rdata_q, rdata_d;
  logic             rd_vld_q, rd_vld_d;

  logic             wr_ctrl, wr_status, clr, rd_lo;
  logic [2:0]       inc_en, ovf_set;
  logic [CNT_W:0]   br_nx, hit_nx, mis_nx;
  logic             unused_wdata;

  assign unused_wdata = ^bus.wdata[15:3];

  // Next counter value with the overflow flag in the top bit. Clear wins over
  // an increment, so an increment lost to a clear does not flag overflow.
  function automatic logic [CNT_W:0] bump(input logic [CNT_W-1:0] cur,
                                          input logic inc, input logic clear);
    logic [CNT_W:0] r;
    r = {1'b0, cur};
    if (clear) begin
      r = '0;
    end else if (inc) begin
      if (&cur) begin
        r = SAT ? {1'b1, cur} : {1'b1, {CNT_W{1'b0}}};
      end else begin
        r = {1'b0, cur + 1'b1};
      end
    end
    return r;
  endfunction

  // Register-port decode and counter/control/status next-state.
  always_comb begin
    wr_ctrl    = bus.we && (bus.addr == A_CTRL);
    wr_status  = bus.we && (bus.addr == A_STATUS);
    clr        = wr_ctrl && bus.wdata[1];
    rd_lo      = bus.re && ((bus.addr == A_BR_LO) || (bus.addr == A_HIT_LO) ||
                            (bus.addr == A_MIS_LO));
    inc_en     = {inc_mispr_cnt, inc_hit_cnt, inc_br_cnt} & {3{~freeze_q}};

    br_nx      = bump(br_cnt_q,  inc_en[0], clr);
    hit_nx     = bump(hit_cnt_q, inc_en[1], clr);
    mis_nx     = bump(mis_cnt_q, inc_en[2], clr);
    br_cnt_d   = br_nx[CNT_W-1:0];
    hit_cnt_d  = hit_nx[CNT_W-1:0];
    mis_cnt_d  = mis_nx[CNT_W-1:0];
    ovf_set    = {mis_nx[CNT_W], hit_nx[CNT_W], br_nx[CNT_W]};

    freeze_d   = wr_ctrl ? bus.wdata[0] : freeze_q;
    // A new overflow beats a simultaneous write-1-to-clear.
    status_d   = (status_q & ~(wr_status ? bus.wdata[2:0] : 3'b000)) | ovf_set;

    // Any LO read freezes the upper halves of all three counters together.
    br_snap_d  = rd_lo ? br_cnt_q[CNT_W-1:16]  : br_snap_q;
    hit_snap_d = rd_lo ? hit_cnt_q[CNT_W-1:16] : hit_snap_q;
    mis_snap_d = rd_lo ? mis_cnt_q[CNT_W-1:16] : mis_snap_q;
  end

  // Read data mux; values are the ones present in the re cycle (pre-write).
  always_comb begin
    rd_vld_d = bus.re;
    rdata_d  = rdata_q;
    if (bus.re) begin
      unique case (bus.addr)
        A_BR_LO:  rdata_d = br_cnt_q[15:0];
        A_BR_HI:  rdata_d = 16'(br_snap_q);
        A_HIT_LO: rdata_d = hit_cnt_q[15:0];
        A_HIT_HI: rdata_d = 16'(hit_snap_q);
        A_MIS_LO: rdata_d = mis_cnt_q[15:0];
        A_MIS_HI: rdata_d = 16'(mis_snap_q);
        A_CTRL:   rdata_d = {15'd0, freeze_q};
        A_STATUS: rdata_d = {13'd0, status_q};
        default:  rdata_d = 16'd0;
      endcase
    end
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q   <= '0;
      hit_cnt_q  <= '0;
      mis_cnt_q  <= '0;
      br_snap_q  <= '0;
      hit_snap_q <= '0;
      mis_snap_q <= '0;
      freeze_q   <= 1'b0;
      status_q   <= 3'b000;
      rdata_q    <= 16'd0;
      rd_vld_q   <= 1'b0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      mis_cnt_q  <= mis_cnt_d;
      br_snap_q  <= br_snap_d;
      hit_snap_q <= hit_snap_d;
      mis_snap_q <= mis_snap_d;
      freeze_q   <= freeze_d;
      status_q   <= status_d;
      rdata_q    <= rdata_d;
      rd_vld_q   <= rd_vld_d;
    end
  end

  assign bus.rdata  = rdata_q;
  assign bus.rd_vld = rd_vld_q;
  assign ovf_irq    = |status_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_stats_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_stats_unit
//  Description : Self-checking bench for branch_stats_unit. A behavioural
//                model holds the counters as plain integers and predicts
//                every read.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_stats_unit;

  localparam int CNT_W = 32;
  localparam longint unsigned MASK = (64'd1 << CNT_W) - 64'd1;
`ifdef BRSTAT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic inc_br_cnt = 1'b0, inc_hit_cnt = 1'b0, inc_mispr_cnt = 1'b0;
  logic ovf_irq;

  branch_stats_unit_if bus_if ();

  branch_stats_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .inc_br_cnt(inc_br_cnt), .inc_hit_cnt(inc_hit_cnt), .inc_mispr_cnt(inc_mispr_cnt),
    .bus(bus_if), .ovf_irq(ovf_irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state
  longint unsigned m_cnt [3];
  longint unsigned m_snap[3];
  bit              m_freeze;
  bit [2:0]        m_status;
  logic [15:0]     m_rdata;
  bit              m_vld;

  typedef struct { logic [3:0] addr; logic [15:0] exp; } rd_vec_t;
  rd_vec_t t_cnt[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_snap[i] = 0; end
    m_freeze = 0; m_status = 0; m_rdata = 0; m_vld = 0;
  endfunction

  function automatic logic [15:0] model_read(input logic [3:0] a);
    logic [15:0] v;
    case (a)
      4'd0, 4'd2, 4'd4: v = 16'(m_cnt[a / 2] % 65536);
      4'd1, 4'd3, 4'd5: v = 16'(m_snap[a / 2]);
      4'd6:             v = {15'd0, m_freeze};
      4'd7:             v = {13'd0, m_status};
      default:          v = 16'd0;
    endcase
    return v;
  endfunction

  function automatic void model_step(input logic r, input logic w, input logic [3:0] a,
                                     input logic [15:0] wd, input logic [2:0] inc);
    bit clear;
    clear = w && a == 4'd6 && wd[1];
    if (r) begin
      m_rdata = model_read(a);
      if (a == 4'd0 || a == 4'd2 || a == 4'd4)
        for (int i = 0; i < 3; i++) m_snap[i] = m_cnt[i] / 65536;
    end
    m_vld = r;
    if (w && a == 4'd7) m_status = m_status & ~wd[2:0];
    for (int i = 0; i < 3; i++) begin
      if (clear) m_cnt[i] = 0;
      else if (inc[i] && !m_freeze) begin
        if (m_cnt[i] == MASK) begin
          m_status[i] = 1'b1;
          m_cnt[i] = SAT ? MASK : 0;
        end else m_cnt[i] = m_cnt[i] + 1;
      end
    end
    if (w && a == 4'd6) m_freeze = wd[0];
  endfunction

  // One clock cycle; called at a negedge, returns at the next negedge.
  task automatic cycle(input logic r, input logic w, input logic [3:0] a,
                       input logic [15:0] wd, input logic [2:0] inc);
    bus_if.re = r; bus_if.we = w; bus_if.addr = a; bus_if.wdata = wd;
    {inc_mispr_cnt, inc_hit_cnt, inc_br_cnt} = inc;
    model_step(r, w, a, wd, inc);
    @(negedge clk);
    chk("rd_vld", {31'd0, bus_if.rd_vld}, {31'd0, m_vld});
    chk("rdata", {16'd0, bus_if.rdata}, {16'd0, m_rdata});
    chk("ovf_irq", {31'd0, ovf_irq}, {31'd0, |m_status});
    bus_if.re = 0; bus_if.we = 0;
    {inc_mispr_cnt, inc_hit_cnt, inc_br_cnt} = 3'b000;
  endtask

  task automatic rd(input logic [3:0] a, input string nm, input logic [15:0] exp);
    cycle(1'b1, 1'b0, a, 16'd0, 3'b000);
    chk(nm, {16'd0, bus_if.rdata}, {16'd0, exp});
  endtask

  initial begin
    t_cnt[0] = '{4'd0, 16'd5};
    t_cnt[1] = '{4'd2, 16'd3};
    t_cnt[2] = '{4'd4, 16'd1};
    t_cnt[3] = '{4'd1, 16'd0};
    t_cnt[4] = '{4'd3, 16'd0};
    t_cnt[5] = '{4'd5, 16'd0};

    bus_if.re = 0; bus_if.we = 0; bus_if.addr = 0; bus_if.wdata = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset rd_vld", {31'd0, bus_if.rd_vld}, 32'd0);
    chk("reset rdata", {16'd0, bus_if.rdata}, 32'd0);
    chk("reset ovf_irq", {31'd0, ovf_irq}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Every offset reads 0 after reset; rd_vld pulses for exactly one cycle.
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), "reset read", 16'd0);
      cycle(1'b0, 1'b0, 4'd0, 16'd0, 3'b000);
    end

    // Overlapping strobes: BR x5, HIT x3, MIS x1.
    cycle(0, 0, 0, 0, 3'b111);
    cycle(0, 0, 0, 0, 3'b011);
    cycle(0, 0, 0, 0, 3'b011);
    cycle(0, 0, 0, 0, 3'b001);
    cycle(0, 0, 0, 0, 3'b001);
    for (int i = 0; i < 6; i++) rd(t_cnt[i].addr, "count table", t_cnt[i].exp);

    // Atomic read across a carry into the upper half.
    @(negedge clk);
    force dut.br_cnt_q = 32'h0001_FFFF;
    #1 release dut.br_cnt_q;
    m_cnt[0] = 64'h1_FFFF;
    rd(4'd0, "atomic lo", 16'hFFFF);
    cycle(0, 0, 0, 0, 3'b001);
    rd(4'd1, "atomic hi snapshot", 16'h0001);
    rd(4'd0, "br lo after carry", 16'h0000);
    rd(4'd1, "br hi after carry", 16'h0002);

    // Freeze, then clear racing an increment.
    cycle(0, 1, 4'd6, 16'd1, 3'b000);
    rd(4'd6, "ctrl freeze", 16'd1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 3'b111);
    rd(4'd2, "hit frozen", 16'd3);
    cycle(0, 1, 4'd6, 16'd0, 3'b000);
    cycle(0, 1, 4'd6, 16'd2, 3'b001);
    rd(4'd0, "br after clear", 16'd0);
    rd(4'd6, "ctrl clear reads 0", 16'd0);

    // Overflow of HIT, then write-1-to-clear.
    @(negedge clk);
    force dut.hit_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.hit_cnt_q;
    m_cnt[1] = MASK;
    cycle(0, 0, 0, 0, 3'b010);
    rd(4'd2, "hit lo after ovf", SAT ? 16'hFFFF : 16'h0000);
    rd(4'd3, "hit hi after ovf", SAT ? 16'hFFFF : 16'h0000);
    rd(4'd7, "status ovf", 16'h0002);
    chk("ovf_irq set", {31'd0, ovf_irq}, 32'd1);
    cycle(0, 1, 4'd7, 16'h0002, 3'b000);
    rd(4'd7, "status cleared", 16'h0000);
    chk("ovf_irq cleared", {31'd0, ovf_irq}, 32'd0);

    // W1C racing a fresh overflow: set wins.
    @(negedge clk);
    force dut.mis_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.mis_cnt_q;
    m_cnt[2] = MASK;
    cycle(0, 1, 4'd7, 16'h0004, 3'b100);
    rd(4'd7, "status set beats w1c", 16'h0004);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic r, w; logic [3:0] a; logic [15:0] wd; logic [2:0] inc;
      r   = ($urandom_range(0, 1) == 1);
      w   = ($urandom_range(0, 9) == 0);
      a   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
      wd  = 16'($urandom);
      inc = 3'($urandom);
      cycle(r, w, a, wd, inc);
    end

    // Asynchronous reset mid-read with counters non-zero.
    cycle(0, 1, 4'd6, 16'd0, 3'b000);
    cycle(0, 0, 0, 0, 3'b111);
    bus_if.re = 1; bus_if.addr = 4'd0; {inc_mispr_cnt, inc_hit_cnt, inc_br_cnt} = 3'b111;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst rd_vld", {31'd0, bus_if.rd_vld}, 32'd0);
    chk("async rst rdata", {16'd0, bus_if.rdata}, 32'd0);
    chk("async rst ovf_irq", {31'd0, ovf_irq}, 32'd0);
    bus_if.re = 0; {inc_mispr_cnt, inc_hit_cnt, inc_br_cnt} = 3'b000;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      rd(4'(a), "post reset read", 16'd0);
      if (a == 0) rd(4'd1, "post reset snap", 16'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
